// File: rtl/sk9822_pkg.sv
// SK9822 strip driver shared types, constants and timing helpers.
// Latency: none (package only).
// Backpressure: none (package only).
package sk9822_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    FETCH,
    LOAD,
    LED,
    END,
    DONE
  } state_t;

  localparam int START_BITS = 32;
  localparam logic [2:0] HEADER = 3'b111;

  // Width of the per-word bit count; also covers long end frames on big strips.
  localparam int NBITS_W = 16;

  // The end frame needs one extra clock edge per two LEDs, rounded up to whole bytes.
  function automatic int end_bits(input int n_leds);
    return 32 + 8 * ((n_leds + 15) / 16);
  endfunction

  // Clocks per serial-clock half cycle, never below one.
  function automatic int half_period(input int clk_mhz, input int spi_khz);
    int hp;
    hp = (clk_mhz * 1000) / (2 * spi_khz);
    return (hp < 1) ? 1 : hp;
  endfunction

endpackage

// File: rtl/sk9822_bit_shifter.sv
// Serialises a loaded word MSB first, one bit per serial clock cycle.
// Latency: first bit on sdata the clock after load; sclk rises half_period clocks later.
// Backpressure: none; load restarts the shifter, word_done pulses after the last falling edge.
module sk9822_bit_shifter
  import sk9822_pkg::*;
#(
  parameter int HALF_PERIOD = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [31:0]        word,
  input  logic [NBITS_W-1:0] nbits,
  input  logic               fill,
  output logic               sclk,
  output logic               sdata,
  output logic               word_done
);

  localparam int TW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [TW-1:0] HP_LAST = TW'(HALF_PERIOD - 1);

  logic [31:0]        sreg;
  logic [NBITS_W-1:0] bits_left;
  logic [TW-1:0]      timer;
  logic               active;
  logic               fill_q;

  // The wire always carries the shift register MSB, so data only moves when sclk falls.
  assign sdata = sreg[31];

  // Half-period timer toggles sclk; each falling edge retires a bit and shifts in fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg      <= '0;
      bits_left <= '0;
      timer     <= '0;
      active    <= 1'b0;
      fill_q    <= 1'b0;
      sclk      <= 1'b0;
      word_done <= 1'b0;
    end else begin
      word_done <= 1'b0;
      if (load) begin
        sreg      <= word;
        bits_left <= nbits;
        timer     <= '0;
        active    <= 1'b1;
        fill_q    <= fill;
        sclk      <= 1'b0;
      end else if (active) begin
        if (timer == HP_LAST) begin
          timer <= '0;
          if (!sclk) begin
            sclk <= 1'b1;
          end else begin
            sclk <= 1'b0;
            if (bits_left == NBITS_W'(1)) begin
              active    <= 1'b0;
              word_done <= 1'b1;
            end else begin
              bits_left <= bits_left - NBITS_W'(1);
              sreg      <= {sreg[30:0], fill_q};
            end
          end
        end else begin
          timer <= timer + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sk9822_strip_driver.sv
// SK9822/APA102 strip driver: start frame, n_leds fetched words, end frame.
// Latency: start at T gives busy and the first start-frame bit at T+1; each word fetched 2 clocks ahead of its bits.
// Backpressure: requests arriving while busy collapse into one pending frame run straight after DONE.
module sk9822_strip_driver
  import sk9822_pkg::*;
#(
  parameter int clk_mhz    = 27,
  parameter int spi_khz    = 1000,
  parameter int n_leds     = 13,
  parameter int refresh_hz = 60,
  parameter int end_ones   = 0,
  parameter int w_idx      = (n_leds > 1) ? $clog2(n_leds) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             auto_refresh,
  input  logic             bright_ovr,
  input  logic [4:0]       global_bright,
  output logic             pix_rd,
  output logic [w_idx-1:0] pix_idx,
  input  logic [31:0]      pix_data,
  output logic             sk9822_clk,
  output logic             sk9822_data,
  output logic             busy,
  output logic             frame_done
);

  localparam int HP       = half_period(clk_mhz, spi_khz);
  localparam int EBITS    = end_bits(n_leds);
  localparam int PERIOD_R = (clk_mhz * 1000000) / refresh_hz;
  localparam int PERIOD   = (PERIOD_R < 1) ? 1 : PERIOD_R;
  localparam int RW       = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [RW-1:0]    R_LAST   = RW'(PERIOD - 1);
  localparam logic [w_idx-1:0] LAST_IDX = w_idx'(n_leds - 1);
  localparam logic             END_FILL = (end_ones != 0);

  state_t             state;
  logic               pending;
  logic [RW-1:0]      rcnt;
  logic               expire;
  logic               request;
  logic               go;
  logic               sh_load;
  logic [31:0]        sh_word;
  logic [NBITS_W-1:0] sh_nbits;
  logic               sh_fill;
  logic               word_done;

  assign expire  = auto_refresh && (rcnt == R_LAST);
  assign request = start || expire;
  assign go      = (state == IDLE) && (request || pending);

  // Free-running refresh timer, held at zero while auto refresh is off.
  always_ff @(posedge clk) begin
    if (rst || !auto_refresh) begin
      rcnt <= '0;
    end else if (expire) begin
      rcnt <= '0;
    end else begin
      rcnt <= rcnt + 1'b1;
    end
  end

  // Frame sequencer: owns busy, the fetch port, frame_done and the pending request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pending    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      pix_rd     <= 1'b0;
      pix_idx    <= '0;
    end else begin
      frame_done <= 1'b0;
      pix_rd     <= 1'b0;
      if (request && (state != IDLE)) begin
        pending <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (go) begin
            state   <= START;
            busy    <= 1'b1;
            pending <= 1'b0;
            pix_idx <= '0;
          end
        end
        START: begin
          if (word_done) begin
            state  <= FETCH;
            pix_rd <= 1'b1;
          end
        end
        FETCH: state <= LOAD;
        LOAD:  state <= LED;
        LED: begin
          if (word_done) begin
            if (pix_idx != LAST_IDX) begin
              pix_idx <= pix_idx + 1'b1;
              pix_rd  <= 1'b1;
              state   <= FETCH;
            end else begin
              state <= END;
            end
          end
        end
        END: begin
          if (word_done) begin
            state      <= DONE;
            frame_done <= 1'b1;
            busy       <= 1'b0;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Selects what the shifter loads: zero start frame, forced LED word, or end-frame fill.
  always_comb begin
    sh_load  = 1'b0;
    sh_word  = '0;
    sh_nbits = NBITS_W'(START_BITS);
    sh_fill  = 1'b0;
    case (state)
      IDLE: sh_load = go;
      LOAD: begin
        sh_load = 1'b1;
        // OR-ing the header in forces 3'b111 whatever the source supplies.
        sh_word = {pix_data[31:29] | HEADER,
                   bright_ovr ? global_bright : pix_data[28:24],
                   pix_data[23:0]};
      end
      LED: begin
        if (word_done && (pix_idx == LAST_IDX)) begin
          sh_load  = 1'b1;
          sh_word  = {32{END_FILL}};
          sh_nbits = NBITS_W'(EBITS);
          sh_fill  = END_FILL;
        end
      end
      default: sh_load = 1'b0;
    endcase
  end

  sk9822_bit_shifter #(
    .HALF_PERIOD(HP)
  ) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .load     (sh_load),
    .word     (sh_word),
    .nbits    (sh_nbits),
    .fill     (sh_fill),
    .sclk     (sk9822_clk),
    .sdata    (sk9822_data),
    .word_done(word_done)
  );

endmodule

// File: tb/tb_sk9822_strip_driver.sv
// Self-checking bench for sk9822_strip_driver: wire-bit scoreboard, fetch-port and framing monitors.
// Latency: checks busy at T+1 and first sclk rise at T+1+half_period.
// Backpressure: exercises start-while-busy collapse and auto refresh.
module tb_sk9822_strip_driver;

  localparam int N          = 3;
  localparam int FRAME_BITS = 32 + 32 * N + 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        auto_refresh;
  logic        bright_ovr;
  logic [4:0]  global_bright;
  logic        pix_rd;
  logic [1:0]  pix_idx;
  logic [31:0] pix_data;
  logic        sk9822_clk;
  logic        sk9822_data;
  logic        busy;
  logic        frame_done;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int frame_bits = 0;
  int frame_rds = 0;
  int exp_idx = 0;
  logic prev_sclk = 1'b0;
  logic prev_data = 1'b0;
  logic prev_rd = 1'b0;
  logic eb;
  logic exp_q[$];
  logic [31:0] mem [0:N-1];

  always #5 clk = ~clk;

  sk9822_strip_driver #(
    .clk_mhz(2), .spi_khz(500), .n_leds(3), .refresh_hz(2000), .end_ones(0)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .auto_refresh(auto_refresh),
    .bright_ovr(bright_ovr), .global_bright(global_bright),
    .pix_rd(pix_rd), .pix_idx(pix_idx), .pix_data(pix_data),
    .sk9822_clk(sk9822_clk), .sk9822_data(sk9822_data),
    .busy(busy), .frame_done(frame_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Expected wire word: header forced, brightness optionally overridden.
  function automatic logic [31:0] exp_word(input logic [31:0] p);
    return {3'b111, bright_ovr ? global_bright : p[28:24], p[23:0]};
  endfunction

  task automatic push_frame();
    logic [31:0] w;
    for (int b = 0; b < 32; b++) exp_q.push_back(1'b0);
    for (int i = 0; i < N; i++) begin
      w = exp_word(mem[i]);
      for (int b = 31; b >= 0; b--) exp_q.push_back(w[b]);
    end
    for (int b = 0; b < 40; b++) exp_q.push_back(1'b0);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int t = 0;
    while (done_cnt < target && t < budget) begin
      @(posedge clk);
      t++;
    end
    check("frame_done_count", 32'(done_cnt), 32'(target));
    #1;
  endtask

  // 1-cycle-latency RAM model: valid word only in the cycle after pix_rd, garbage otherwise.
  always @(posedge clk) begin
    if (pix_rd && pix_idx < 2'(N)) pix_data <= mem[pix_idx];
    else pix_data <= $urandom();
  end

  // Wire, fetch-port and framing monitor sampled on the falling system clock edge.
  always @(negedge clk) begin
    if (rst) begin
      frame_bits = 0;
      frame_rds  = 0;
      exp_idx    = 0;
    end else begin
      if (sk9822_clk && !prev_sclk) begin
        frame_bits++;
        check("bit_expected", 32'(exp_q.size() != 0), 32'(1));
        if (exp_q.size() != 0) begin
          eb = exp_q.pop_front();
          check("wire_bit", 32'(sk9822_data), 32'(eb));
        end
      end
      if (sk9822_clk && prev_sclk) check("data_stable_high", 32'(sk9822_data), 32'(prev_data));
      if (!busy) check("sclk_idle_low", 32'(sk9822_clk), 32'(0));
      if (pix_rd) begin
        check("pix_idx_seq", 32'(pix_idx), 32'(exp_idx));
        check("pix_rd_single", 32'(prev_rd), 32'(0));
        exp_idx = (exp_idx + 1) % N;
        frame_rds++;
      end
      if (frame_done) begin
        done_cnt++;
        check("sclk_edges_per_frame", 32'(frame_bits), 32'(FRAME_BITS));
        check("pix_rd_per_frame", 32'(frame_rds), 32'(N));
        check("busy_at_done", 32'(busy), 32'(0));
        frame_bits = 0;
        frame_rds  = 0;
        exp_idx    = 0;
      end
    end
    prev_sclk = sk9822_clk;
    prev_data = sk9822_data;
    prev_rd   = pix_rd;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; auto_refresh = 1'b0;
    bright_ovr = 1'b0; global_bright = 5'd0;
    mem[0] = 32'hE1FF0000; mem[1] = 32'hE100FF00; mem[2] = 32'hE10000FF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sclk", 32'(sk9822_clk), 32'(0));
    check("rst_data", 32'(sk9822_data), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_frame_done", 32'(frame_done), 32'(0));
    check("rst_pix_rd", 32'(pix_rd), 32'(0));
    check("rst_pix_idx", 32'(pix_idx), 32'(0));
    rst = 1'b0;
    repeat (6) @(posedge clk);

    // Basic frame with latency checks.
    push_frame();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("busy_t_plus_1", 32'(busy), 32'(1));
    check("sclk_low_t_plus_1", 32'(sk9822_clk), 32'(0));
    check("first_bit_zero", 32'(sk9822_data), 32'(0));
    @(posedge clk); #1;
    check("sclk_low_t_plus_2", 32'(sk9822_clk), 32'(0));
    @(posedge clk); #1;
    check("sclk_rise_t_plus_3", 32'(sk9822_clk), 32'(1));
    wait_done(1, 2000);
    check("busy_after_frame", 32'(busy), 32'(0));
    check("pix_idx_holds_last", 32'(pix_idx), 32'(N - 1));
    check("queue_empty_s1", 32'(exp_q.size()), 32'(0));

    // Header forcing and brightness override.
    for (int i = 0; i < N; i++) mem[i] = 32'h00123456;
    bright_ovr = 1'b1; global_bright = 5'd3;
    push_frame();
    pulse_start();
    wait_done(2, 2000);
    check("queue_empty_s2", 32'(exp_q.size()), 32'(0));
    bright_ovr = 1'b0; global_bright = 5'd0;

    // Start while busy collapses into exactly one follow-on frame.
    mem[0] = 32'hE1FF0000; mem[1] = 32'hE100FF00; mem[2] = 32'hE10000FF;
    push_frame();
    push_frame();
    pulse_start();
    repeat (100) @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      pulse_start();
      repeat (50) @(posedge clk);
    end
    wait_done(3, 2000);
    repeat (3) @(posedge clk);
    #1;
    check("pending_restart", 32'(busy), 32'(1));
    wait_done(4, 2000);
    repeat (200) @(posedge clk);
    #1;
    check("no_third_frame", 32'(done_cnt), 32'(4));
    check("idle_after_pending", 32'(busy), 32'(0));
    check("queue_empty_s3", 32'(exp_q.size()), 32'(0));

    // Auto refresh every 1000 clocks, held a little past 5000 clocks.
    for (int f = 0; f < 5; f++) push_frame();
    @(posedge clk); #1 auto_refresh = 1'b1;
    repeat (5200) @(posedge clk);
    #1 auto_refresh = 1'b0;
    wait_done(9, 3000);
    repeat (1500) @(posedge clk);
    #1;
    check("auto_frame_count", 32'(done_cnt), 32'(9));
    check("auto_idle", 32'(busy), 32'(0));
    check("queue_empty_s4", 32'(exp_q.size()), 32'(0));

    // Reset during the second LED word aborts without frame_done.
    push_frame();
    pulse_start();
    repeat (300) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("abort_sclk", 32'(sk9822_clk), 32'(0));
    check("abort_data", 32'(sk9822_data), 32'(0));
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_pix_idx", 32'(pix_idx), 32'(0));
    rst = 1'b0;
    exp_q.delete();
    repeat (300) @(posedge clk);
    #1;
    check("no_done_after_abort", 32'(done_cnt), 32'(9));
    mem[0] = 32'hFF010203; mem[1] = 32'h1F0A0B0C; mem[2] = 32'h00FFFFFF;
    push_frame();
    pulse_start();
    wait_done(10, 2000);
    check("queue_empty_s5", 32'(exp_q.size()), 32'(0));
    check("final_idle", 32'(busy), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sk9822_strip_driver.md
Name: sk9822_strip_driver

Overview:
Parametrised SK9822/APA102 two-wire LED strip driver. It serialises a start frame, N 32-bit LED words and an end frame onto `sk9822_clk` and `sk9822_data`. It supersedes the fixed 13-LED, parallel-input strip driver in board tops. LED words are fetched one at a time through an indexed read port, so the pixel source can be a register file or a 1-cycle-latency RAM. Supports single-shot and periodic refresh, plus an optional global-brightness override.

Parameters:
clk_mhz, 27, system clock frequency in MHz
spi_khz, 1000, target serial clock in kHz; half_period = max(1, clk_mhz*1000/(2*spi_khz)) clocks
n_leds, 13, LEDs on the strip (>=1)
refresh_hz, 60, frame rate in auto mode
end_ones, 0, end-frame fill value (0: zeros, 1: ones)
w_idx, $clog2(n_leds) (min 1), width of pix_idx

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
start  input  1  single-cycle frame request
auto_refresh  input  1  1: start a frame every clk_mhz*1e6/refresh_hz clocks
bright_ovr  input  1  1: replace bits [28:24] of every LED word with global_bright
global_bright  input  5  override brightness
pix_rd  output  1  read strobe, one cycle per LED
pix_idx  output  w_idx  LED index being fetched, 0..n_leds-1
pix_data  input  32  LED word {3'b111, bright[4:0], B, G, R}; must be valid the cycle after pix_rd
sk9822_clk  output  1  serial clock, idles low
sk9822_data  output  1  serial data, MSB first
busy  output  1  frame in progress
frame_done  output  1  one-cycle pulse after the last end-frame bit

Behaviour:
- Reset values:
  - Outputs: sk9822_clk=0, sk9822_data=0, busy=0, frame_done=0, pix_rd=0, pix_idx=0.
  - Internal: pending=0, refresh counter=0, FSM=IDLE.
  - rst mid-frame aborts the frame immediately; no frame_done is issued.
- Bit timing:
  - sk9822_data changes only while sk9822_clk is low, at the start of each bit.
  - sk9822_clk is low for half_period clocks, then high for half_period clocks.
  - One bit therefore takes 2*half_period clocks.
- Word forcing:
  - Bits [31:29] are always forced to 3'b111 regardless of pix_data.
  - When bright_ovr=1, [28:24] = global_bright.
  - bright_ovr and global_bright are sampled at load time, per LED.
- FSM states: IDLE, START, FETCH, LOAD, LED, END, DONE.
  - IDLE: moves to START when start=1, pending=1, or the auto timer expires. busy=1 from the next cycle.
  - START: shifts 32 zero bits, then goes to FETCH.
  - FETCH: pix_rd=1 for one clock with pix_idx=i, then goes to LOAD.
  - LOAD: captures pix_data with the forced bits into the shift register, then goes to LED.
  - LED: shifts 32 bits. If i<n_leds-1, increments i and returns to FETCH; otherwise goes to END. The fetch/load gap (2 clocks) is inserted with sk9822_clk held low.
  - END: shifts end_bits = 32 + 8*ceil(n_leds/16) bits of the end_ones value, then goes to DONE.
  - DONE: frame_done=1 for one clock, sk9822_clk=0, busy=0, then IDLE.
- Latency:
  - start at cycle T gives busy=1 and the first START bit driven at T+1.
  - The first rising edge of sk9822_clk is at T+1+half_period.
- Requests:
  - start while busy sets pending; multiple requests collapse into one.
  - start coincident with DONE also sets pending, and the frame restarts after DONE.
- Auto refresh:
  - The counter runs freely while auto_refresh=1 and clears when auto_refresh=0.
  - Expiry while busy sets pending; frames are never dropped silently or overlapped.
- Index behaviour: pix_idx holds its last value outside FETCH and resets to 0 at each frame start.
- n_leds=1: a single FETCH/LED pass, then END with end_bits=40.

Decomposition:
- Package sk9822_pkg holds:
  - the state enum typedef;
  - constants START_BITS=32 and HEADER=3'b111;
  - the function end_bits(n_leds);
  - the function half_period(clk_mhz, spi_khz).
- One natural sub-module, sk9822_bit_shifter. Its job:
  - a 32-bit shift register with a bit counter and half-period timer;
  - inputs load, word, nbits, fill;
  - outputs sclk, sdata, word_done.
- The top FSM sequences frames and the fetch port.

Test Plan:
Bench parameters for all scenarios: n_leds=3, clk_mhz=2, spi_khz=500 (half_period=2).
1. Basic frame: pix_data = 0xE1FF0000, 0xE100FF00, 0xE10000FF; pulse start at T=10.
   - Expect busy at T=11.
   - Expect captured bits = 32 zeros, then the three words MSB-first, then 40 zeros.
   - Total 168 sclk rising edges.
   - Expect one frame_done pulse and busy=0 after it.
2. Header forcing and brightness override: pix_data=0x00123456 with bright_ovr=1, global_bright=5'd3.
   - Expect every word on the wire = 0xE3123456.
3. Start while busy: pulse start three times mid-frame.
   - Expect exactly one further frame immediately after frame_done, then IDLE.
4. Auto refresh with refresh_hz tuned to 1000 clocks: hold auto_refresh=1 for 5000 clocks.
   - Expect 5 frames, sk9822_clk idle low between frames, no overlap.
5. Reset mid-frame: assert rst during the second LED word.
   - Expect sk9822_clk=0, sk9822_data=0, busy=0 on the next clock, and no frame_done.
   - A subsequent start produces a full correct frame from pix_idx=0.
6. RAM latency: the bench model returns pix_data exactly one clock after pix_rd, with garbage otherwise.
   - Expect correct words on the wire.
   - Expect pix_idx sequence 0,1,2 with exactly one pix_rd pulse per LED.
